// File: rtl/sincos_cordic_iter.sv
// Iterative CORDIC sine/cosine, one micro-rotation per enabled clock, valid/ready on both sides.
// Define SINCOS_QUADRANT_FOLD_EN to accept [-pi, pi); otherwise angles are clamped to +/-pi/2.
module sincos_cordic_iter #(
    parameter int WIDTH = 21,
    parameter int FRAC  = 16,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] sin,
    output logic signed [WIDTH-1:0] cos
);
    localparam int ZW = WIDTH + 2;
    localparam int F2 = FRAC + 2;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam longint unsigned PI_Q60  = 64'h3243F6A8885A308D;
    localparam longint unsigned PI4_Q60 = 64'h0C90FDAA22168C23;

    // Round a Q.60 constant to nearest at f fraction bits.
    function automatic longint unsigned rnd_q60(input longint unsigned v, input int unsigned f);
        return ((v >> (59 - f)) + 64'd1) >> 1;
    endfunction

    // atan(2^-n) in Q.60 via the alternating Taylor series (n >= 1 converges quickly).
    function automatic longint unsigned atan_q60(input int unsigned n);
        longint unsigned acc;
        longint unsigned term;
        int unsigned     e;
        if (n == 0) return PI4_Q60;
        acc = '0;
        for (int unsigned k = 0; k < 40; k++) begin
            e = n * (2 * k + 1);
            if (e <= 60) begin
                term = (64'd1 << (60 - e)) / 64'(2 * k + 1);
                if (k % 2 == 0) acc = acc + term;
                else            acc = acc - term;
            end
        end
        return acc;
    endfunction

    localparam logic signed [ZW-1:0]    K_Z   = ZW'((((64'd6072529350 << (F2 + 1)) / 64'd10000000000) + 64'd1) >> 1);
    localparam logic signed [ZW-1:0]    HPI_Z = ZW'(rnd_q60(PI_Q60 >> 1, F2));
    localparam logic signed [ZW-1:0]    PI_Z  = ZW'(rnd_q60(PI_Q60, F2));
    localparam logic signed [WIDTH-1:0] HPI_A = WIDTH'(rnd_q60(PI_Q60 >> 1, FRAC));
    localparam logic signed [ZW:0]      RND   = 2;
    localparam logic signed [ZW:0]      SMAX  = {4'b0000, {(WIDTH-1){1'b1}}};
    localparam logic signed [ZW:0]      SMIN  = {4'b1111, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ROT, FIX, DONE} state_t;

    state_t                 state;
    logic signed [ZW-1:0]   x, y, z;
    logic        [IW-1:0]   i;
    logic signed [ZW-1:0]   xs, ys, ang_z, z_load;
    logic signed [ZW-1:0]   atan_tab [ITER];
    logic                   neg_fix;

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        assign atan_tab[g] = ZW'(rnd_q60(atan_q60(g), F2));
    end

    assign ang_z     = {angle, 2'b00};
    assign xs        = x >>> i;
    assign ys        = y >>> i;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef SINCOS_QUADRANT_FOLD_EN
    logic fold, fold_load;
    always_comb begin
        z_load    = ang_z;
        fold_load = 1'b0;
        if (angle > HPI_A) begin
            z_load    = ang_z - PI_Z;
            fold_load = 1'b1;
        end else if (angle < -HPI_A) begin
            z_load    = ang_z + PI_Z;
            fold_load = 1'b1;
        end
    end
    assign neg_fix = fold;
`else
    always_comb begin
        z_load = ang_z;
        if (angle > HPI_A)       z_load = HPI_Z;
        else if (angle < -HPI_A) z_load = -HPI_Z;
    end
    assign neg_fix = 1'b0;
`endif

    // Optional negation, drop the 2 guard bits with round-half-up, clip to WIDTH.
    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ZW-1:0] v, input logic neg);
        logic signed [ZW:0] e;
        logic signed [ZW:0] r;
        e = {v[ZW-1], v};
        if (neg) e = -e;
        r = (e + RND) >>> 2;
        if (r > SMAX)      return SMAX[WIDTH-1:0];
        else if (r < SMIN) return SMIN[WIDTH-1:0];
        return r[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            i     <= '0;
            sin   <= '0;
            cos   <= '0;
`ifdef SINCOS_QUADRANT_FOLD_EN
            fold  <= 1'b0;
`endif
        end else if (en) begin
            case (state)
                IDLE: if (in_valid) begin
                    x     <= K_Z;
                    y     <= '0;
                    z     <= z_load;
                    i     <= '0;
`ifdef SINCOS_QUADRANT_FOLD_EN
                    fold  <= fold_load;
`endif
                    state <= ROT;
                end
                ROT: begin
                    if (z[ZW-1]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + atan_tab[i];
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - atan_tab[i];
                    end
                    i <= i + 1'b1;
                    if (i == IW'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    sin   <= round_sat(y, neg_fix);
                    cos   <= round_sat(x, neg_fix);
                    state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sincos_cordic_iter.sv
// Directed bench for sincos_cordic_iter (WIDTH=21, FRAC=16, ITER=16); results checked to +/-4 LSB.
module tb_sincos_cordic_iter;
    localparam int W   = 21;
    localparam int TOL = 4;
    localparam int LAT = 17;

    logic                clk, rst, en, in_valid, in_ready, out_valid, out_ready;
    logic signed [W-1:0] angle, sin, cos;
    int errors = 0;
    int checks = 0;

    sincos_cordic_iter #(.WIDTH(21), .FRAC(16), .ITER(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .angle(angle), .out_valid(out_valid), .out_ready(out_ready), .sin(sin), .cos(cos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an angle for one cycle; returns at the negedge after the accepting edge.
    task automatic start(input logic signed [W-1:0] a);
        angle    = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(inout int n);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; angle = '0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (sin !== 21'sd0) begin errors++; $display("FAIL reset_sin got=%0d want=0", sin); end
        checks++; if (cos !== 21'sd0) begin errors++; $display("FAIL reset_cos got=%0d want=0", cos); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_angle(input string name, input logic signed [W-1:0] a, input int es, input int ec);
        int n;
        start(a);
        n = 0;
        wait_done(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, n, LAT); end
        checks++; if (int'(sin) < es - TOL || int'(sin) > es + TOL) begin errors++; $display("FAIL %s_sin got=%0d want=%0d", name, sin, es); end
        checks++; if (int'(cos) < ec - TOL || int'(cos) > ec + TOL) begin errors++; $display("FAIL %s_cos got=%0d want=%0d", name, cos, ec); end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_handoff got ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        start(21'sd34315);
        n = 0;
        wait_done(n);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            if (int'(sin) < 32768 - TOL || int'(sin) > 32768 + TOL || int'(cos) < 56756 - TOL || int'(cos) > 56756 + TOL) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad); end
        en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_low_handshake got ov=%b want=1", out_valid); end
        en = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_transfer got ov=%b want=0", out_valid); end
    endtask

    task automatic test_enable_stall();
        int n;
        start(-21'sd34315);
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        en = 1'b0;
        repeat (5) begin @(negedge clk); n++; end
        en = 1'b1;
        wait_done(n);
        checks++; if (n != LAT + 5) begin errors++; $display("FAIL stall_latency got=%0d want=%0d", n, LAT + 5); end
        checks++; if (int'(sin) < -32768 - TOL || int'(sin) > -32768 + TOL) begin errors++; $display("FAIL stall_sin got=%0d want=-32768", sin); end
        checks++; if (int'(cos) < 56756 - TOL || int'(cos) > 56756 + TOL) begin errors++; $display("FAIL stall_cos got=%0d want=56756", cos); end
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        start(21'sd34315);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flags got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
        checks++; if (sin !== 21'sd0 || cos !== 21'sd0) begin errors++; $display("FAIL midreset_data got sin=%0d cos=%0d want 0 0", sin, cos); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (25) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_stale got=%0d valid cycles want=0", seen); end
        start(21'sd0);
        n = 0;
        wait_done(n);
        checks++; if (int'(cos) < 65536 - TOL || int'(cos) > 65536 + TOL) begin errors++; $display("FAIL midreset_cos got=%0d want=65536", cos); end
        drain();
    endtask

    task automatic test_back_to_back();
        int first, second, pulses, overlap;
        first = -1; second = -1; pulses = 0; overlap = 0;
        out_ready = 1'b1;
        angle     = '0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 57; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                pulses++;
                if (in_ready === 1'b1) overlap++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        in_valid = 1'b0;
        checks++; if (second - first != LAT + 2) begin errors++; $display("FAIL b2b_period got=%0d want=%0d", second - first, LAT + 2); end
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap got=%0d want=0", overlap); end
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_angle("zero",  21'sd0,        0,      65536);
        test_angle("hpi",   21'sd102944,   65536,  0);
        test_angle("mhpi", -21'sd102944,  -65536,  0);
        test_angle("pi6",   21'sd34315,    32768,  56756);
        test_angle("mpi6", -21'sd34315,   -32768,  56756);
`ifdef SINCOS_QUADRANT_FOLD_EN
        test_angle("tq",    21'sd154415,   46341, -46341);
        test_angle("mtq",  -21'sd154415,  -46341, -46341);
`else
        test_angle("tq",    21'sd154415,   65536,  0);
        test_angle("mtq",  -21'sd154415,  -65536,  0);
`endif
        test_backpressure();
        test_enable_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
